// File: rtl/natv_dbg_master.sv
// Debug/boot bus master: parses read/write command packets from a byte stream,
// issues one native valid/ready bus transaction per packet, and streams back a status byte plus any read data.
module natv_dbg_master #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        natv_valid_o,
    output logic [31:0] natv_addr_o,
    output logic [31:0] natv_wdata_o,
    output logic [3:0]  natv_wstrb_o,
    input  logic [31:0] natv_rdata_i,
    input  logic        natv_ready_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_e;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_TMO   = 8'h01;
    localparam logic [7:0] ST_BADOP = 8'h02;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  status_q, status_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic        rx_ready_q, rx_ready_d;
    logic        natv_valid_q, natv_valid_d;
    logic        tx_valid_q, tx_valid_d;

    logic        rx_fire;
    logic        tx_fire;
    logic        tmo_hit;
    logic [2:0]  tx_last;

    assign rx_fire = rx_valid_i && rx_ready_q;
    assign tx_fire = tx_valid_q && tx_ready_i;
    assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CYC - 1));
    // Writes and bad opcodes answer with the status byte alone; reads append 4 data bytes.
    assign tx_last = (is_write_q || status_q == ST_BADOP) ? 3'd0 : 3'd4;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            tx_idx_q     <= '0;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            status_q     <= '0;
            tmo_q        <= '0;
            rx_ready_q   <= 1'b0;
            natv_valid_q <= 1'b0;
            tx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            tx_idx_q     <= tx_idx_d;
            is_write_q   <= is_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            status_q     <= status_d;
            tmo_q        <= tmo_d;
            rx_ready_q   <= rx_ready_d;
            natv_valid_q <= natv_valid_d;
            tx_valid_q   <= tx_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rx_data_i == OP_READ || rx_data_i == OP_WRITE) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire && byte_cnt_q == 2'd3) begin
                    state_d = is_write_q ? S_DATA : S_BUS;
                end
            end
            S_DATA: begin
                if (rx_fire && byte_cnt_q == 2'd3) begin
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (natv_ready_i || tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_fire && tx_idx_q == tx_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        tx_idx_d   = tx_idx_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        tmo_d      = '0;
        case (state_q)
            S_IDLE: begin
                byte_cnt_d = '0;
                tx_idx_d   = '0;
                if (rx_fire) begin
                    is_write_d = (rx_data_i == OP_WRITE);
                    if (rx_data_i != OP_READ && rx_data_i != OP_WRITE) begin
                        status_d = ST_BADOP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            S_BUS: begin
                tmo_d = tmo_q + CNT_W'(1);
                // A same-edge ready beats the timeout.
                if (natv_ready_i) begin
                    rdata_d  = natv_rdata_i;
                    status_d = ST_OK;
                end else if (tmo_hit) begin
                    rdata_d  = '0;
                    status_d = ST_TMO;
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    tx_idx_d = tx_idx_q + 3'd1;
                end
            end
            default: ;
        endcase
        rx_ready_d   = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
        natv_valid_d = (state_d == S_BUS);
        tx_valid_d   = (state_d == S_RESP);
    end

    always_comb begin
        case (tx_idx_q)
            3'd1:    tx_data_o = rdata_q[7:0];
            3'd2:    tx_data_o = rdata_q[15:8];
            3'd3:    tx_data_o = rdata_q[23:16];
            3'd4:    tx_data_o = rdata_q[31:24];
            default: tx_data_o = status_q;
        endcase
        busy_o = (state_q != S_IDLE);
    end

    assign rx_ready_o   = rx_ready_q;
    assign tx_valid_o   = tx_valid_q;
    assign natv_valid_o = natv_valid_q;
    assign natv_addr_o  = addr_q;
    assign natv_wdata_o = wdata_q;
    assign natv_wstrb_o = {4{is_write_q}};

endmodule

// File: tb/tb_natv_dbg_master.sv
// Randomized bench for natv_dbg_master: drives command packets, plays the bus
// responder, and compares responses against a packet-level reference model.
module tb_natv_dbg_master;

    localparam int TIMEOUT_CYC = 1024;
    localparam int NEVER       = 1 << 30;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b0;
    logic        natv_valid_o;
    logic [31:0] natv_addr_o;
    logic [31:0] natv_wdata_o;
    logic [3:0]  natv_wstrb_o;
    logic [31:0] natv_rdata_i = '0;
    logic        natv_ready_i = 1'b0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    natv_dbg_master #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_ready_o   (rx_ready_o),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_ready_i   (tx_ready_i),
        .natv_valid_o (natv_valid_o),
        .natv_addr_o  (natv_addr_o),
        .natv_wdata_o (natv_wdata_o),
        .natv_wstrb_o (natv_wstrb_o),
        .natv_rdata_i (natv_rdata_i),
        .natv_ready_i (natv_ready_i),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one command byte after an idle gap; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        int n = 0;
        rx_valid_i = 1'b0;
        repeat (gap) @(negedge clk_i);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!acc && n < 50) begin
            acc = rx_ready_o;
            @(negedge clk_i);
            n++;
        end
        rx_valid_i = 1'b0;
        check("rx_accept", 32'(acc), 32'd1);
    endtask

    task automatic run_pkt(input string name, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int wait_cyc,
                           input int rx_gap_max, input int stall_min, input int stall_max);
        logic [7:0]  exp_q[$];
        logic [31:0] d;
        logic [7:0]  st;
        logic [7:0]  first;
        logic [3:0]  exp_strb;
        bit          is_rd = (op == 8'h01);
        bit          is_wr = (op == 8'h02);
        int          high = 0;
        int          unstable = 0;
        int          hold_err = 0;
        int          exp_high;
        int          stall;

        $display("pkt %s op=%02h addr=%08h wdata=%08h rdata=%08h wait=%0d", name, op, addr, wdata, rdata, wait_cyc);
        // Reference model: response bytes follow directly from the packet rules.
        if (!is_rd && !is_wr) begin
            exp_q.push_back(8'h02);
        end else begin
            st = (wait_cyc < TIMEOUT_CYC) ? 8'h00 : 8'h01;
            d  = (wait_cyc < TIMEOUT_CYC) ? rdata : 32'h0;
            exp_q.push_back(st);
            if (is_rd) for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
        end
        exp_high = (wait_cyc < TIMEOUT_CYC) ? wait_cyc + 1 : TIMEOUT_CYC;
        exp_strb = is_wr ? 4'hF : 4'h0;

        send_byte(op, $urandom_range(rx_gap_max, 0));
        if (is_rd || is_wr) begin
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], $urandom_range(rx_gap_max, 0));
            if (is_wr) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8], $urandom_range(rx_gap_max, 0));
            check({name, ":valid_rise"}, 32'(natv_valid_o), 32'd1);
            check({name, ":rx_ready_bus"}, 32'(rx_ready_o), 32'd0);
            check({name, ":busy_bus"}, 32'(busy_o), 32'd1);
            check({name, ":addr"}, natv_addr_o, addr);
            check({name, ":wstrb"}, 32'(natv_wstrb_o), 32'(exp_strb));
            if (is_wr) check({name, ":wdata"}, natv_wdata_o, wdata);
            while (natv_valid_o && high < TIMEOUT_CYC + 8) begin
                if (natv_addr_o !== addr || natv_wstrb_o !== exp_strb || (is_wr && natv_wdata_o !== wdata))
                    unstable++;
                natv_ready_i = (high >= wait_cyc);
                natv_rdata_i = natv_ready_i ? rdata : $urandom;
                @(negedge clk_i);
                high++;
            end
            natv_ready_i = 1'b0;
            natv_rdata_i = $urandom;
            check({name, ":valid_cycles"}, 32'(high), 32'(exp_high));
            check({name, ":bus_stable"}, 32'(unstable), 32'd0);
        end

        for (int i = 0; i < exp_q.size(); i++) begin
            stall = $urandom_range(stall_max, stall_min);
            check({name, ":tx_valid"}, 32'(tx_valid_o), 32'd1);
            first = tx_data_o;
            repeat (stall) begin
                tx_ready_i = 1'b0;
                @(negedge clk_i);
                if (tx_data_o !== first || tx_valid_o !== 1'b1) hold_err++;
            end
            tx_ready_i = 1'b1;
            check({name, ":tx_byte"}, 32'(tx_data_o), 32'(exp_q[i]));
            @(negedge clk_i);
        end
        tx_ready_i = 1'b0;
        check({name, ":tx_done"}, 32'(tx_valid_o), 32'd0);
        check({name, ":rx_ready_back"}, 32'(rx_ready_o), 32'd1);
        check({name, ":busy_idle"}, 32'(busy_o), 32'd0);
        check({name, ":tx_hold"}, 32'(hold_err), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, ":rx_ready"}, 32'(rx_ready_o), 32'd0);
        check({name, ":tx_valid"}, 32'(tx_valid_o), 32'd0);
        check({name, ":tx_data"}, 32'(tx_data_o), 32'd0);
        check({name, ":natv_valid"}, 32'(natv_valid_o), 32'd0);
        check({name, ":addr"}, natv_addr_o, 32'd0);
        check({name, ":wdata"}, natv_wdata_o, 32'd0);
        check({name, ":wstrb"}, 32'(natv_wstrb_o), 32'd0);
        check({name, ":busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] addr;
        int          r;

        #3 rst_n_i = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        run_pkt("t1_write", 8'h02, 32'h2000_0000, 32'h1234_5678, 32'h0, 3, 0, 0, 0);
        run_pkt("t2_read", 8'h01, 32'h0300_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        run_pkt("t3_timeout", 8'h01, 32'h4000_0010, 32'h0, 32'hCAFE_F00D, NEVER, 0, 0, 0);
        run_pkt("t4_badop", 8'h7F, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        run_pkt("t4_after", 8'h01, 32'h1111_2222, 32'h0, 32'h0BAD_CAFE, 1, 0, 0, 0);
        run_pkt("t5_backpr", 8'h01, 32'h0000_0ABC, 32'h0, 32'h8899_AABB, 2, 1, 5, 5);

        // Reset while the bus request is outstanding.
        $display("pkt t6_reset op=01 addr=00005000 (reset during bus phase)");
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (3) @(negedge clk_i);
        check("t6:valid_before", 32'(natv_valid_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1 check_all_zero("t6_async");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        run_pkt("t6_clean", 8'h01, 32'h0000_5000, 32'h0, 32'h1357_9BDF, 0, 0, 0, 1);

        for (int k = 0; k < 30; k++) begin
            r    = $urandom_range(9, 0);
            addr = $urandom;
            if (r < 4)      op = 8'h01;
            else if (r < 8) op = 8'h02;
            else            op = 8'($urandom_range(255, 3));
            run_pkt($sformatf("rnd%0d", k), op, addr, $urandom, $urandom,
                    $urandom_range(5, 0), 2, 0, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
